// File: rtl/cselect_adder_16_4.sv
// rtl/cselect_adder_16_4.sv - 16-bit carry-select adder from 4-bit ripple blocks, registered output

// Single full-adder cell used by every ripple chain
module cselect_fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ c;
    assign co = (a & b) | (c & (a ^ b));
endmodule

// BLOCK-bit ripple-carry adder built from a chain of full-adder cells
module cselect_ripple_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout
);
    logic [BLOCK:0] c;

    assign c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < BLOCK; i++) begin : g_bit
            cselect_fa_cell u_fa (
                .a  (a[i]),
                .b  (b[i]),
                .c  (c[i]),
                .s  (s[i]),
                .co (c[i+1])
            );
        end
    endgenerate

    assign cout = c[BLOCK];
endmodule

// Top: combinational carry-select core followed by a one-stage result register
module cselect_adder_16_4 #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NB = WIDTH / BLOCK;

    // blk_c[k] is the resolved carry into block k; blk_c[NB] is the adder carry out
    logic [NB:0]      blk_c;
    logic [WIDTH-1:0] core_sum;

    assign blk_c[0] = 1'b0;

    genvar k;
    generate
        for (k = 0; k < NB; k++) begin : g_blk
            logic [BLOCK-1:0] s0;
            logic             c0;

            // Carry-in-0 chain exists for every block; block 0 uses it directly
            cselect_ripple_block #(.BLOCK(BLOCK)) u_rc0 (
                .a    (a[k*BLOCK +: BLOCK]),
                .b    (b[k*BLOCK +: BLOCK]),
                .cin  (1'b0),
                .s    (s0),
                .cout (c0)
            );

            if (k == 0) begin : g_first
                assign core_sum[BLOCK-1:0] = s0;
                assign blk_c[1]            = c0;
            end else begin : g_sel
                logic [BLOCK-1:0] s1;
                logic             c1;

                // Speculative carry-in-1 chain, evaluated in parallel with the cin=0 chain
                cselect_ripple_block #(.BLOCK(BLOCK)) u_rc1 (
                    .a    (a[k*BLOCK +: BLOCK]),
                    .b    (b[k*BLOCK +: BLOCK]),
                    .cin  (1'b1),
                    .s    (s1),
                    .cout (c1)
                );

                // The real carry from the block below picks which speculation was right
                assign core_sum[k*BLOCK +: BLOCK] = blk_c[k] ? s1 : s0;
                assign blk_c[k+1]                 = blk_c[k] ? c1 : c0;
            end
        end
    endgenerate

    // Result register: capture on valid, hold data and drop valid otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= core_sum;
                cout <= blk_c[NB];
            end
        end
    end
endmodule

// File: tb/tb_cselect_adder_16_4.sv
// tb/tb_cselect_adder_16_4.sv - self-checking bench for cselect_adder_16_4
module tb_cselect_adder_16_4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic [15:0] sum;
    logic        cout;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    cselect_adder_16_4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 17-bit unsigned addition
    function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y);
        return 17'(x) + 17'(y);
    endfunction

    task automatic check_result(input string name, input logic [16:0] exp, input logic exp_valid);
        check({name, "_valid"}, 32'(out_valid), 32'(exp_valid));
        check({name, "_sum"},   32'(sum),       32'(exp[15:0]));
        check({name, "_cout"},  32'(cout),      32'(exp[16]));
    endtask

    initial begin
        logic [16:0] last_result;
        logic        exp_valid;

        vecs[0] = '{16'h000F, 16'h0001, 17'h00010};
        vecs[1] = '{16'hFFFF, 16'h0001, 17'h10000};
        vecs[2] = '{16'h8000, 16'h8000, 17'h10000};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE};
        vecs[4] = '{16'h0000, 16'h0000, 17'h00000};
        vecs[5] = '{16'h1234, 16'h4321, 17'h05555};
        vecs[6] = '{16'h00FF, 16'h0001, 17'h00100};
        vecs[7] = '{16'h0FFF, 16'h0001, 17'h01000};
        vecs[8] = '{16'h7FFF, 16'h0001, 17'h08000};
        vecs[9] = '{16'hABCD, 16'h5433, 17'h10000};

        // Asynchronous reset assertion between clock edges
        #2 rst_n = 1'b0;
        #1 check_result("reset_async", 17'h0, 1'b0);

        // Reset must dominate a valid operation at a clock edge
        in_valid = 1'b1;
        a = 16'hFFFF;
        b = 16'hFFFF;
        @(negedge clk);
        check_result("reset_held", 17'h0, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // Directed table, one operation at a time
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = vecs[i].a;
            b = vecs[i].b;
            in_valid = 1'b1;
            @(negedge clk);
            check_result($sformatf("vec%0d", i), vecs[i].exp, 1'b1);
        end
        last_result = vecs[9].exp;

        // in_valid low: valid drops, data holds even though operands change
        in_valid = 1'b0;
        a = 16'h1234;
        b = 16'h0001;
        @(negedge clk);
        check_result("hold1", last_result, 1'b0);
        @(negedge clk);
        check_result("hold2", last_result, 1'b0);

        // Back-to-back random stream with periodic idle cycles
        exp_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            check_result($sformatf("rand%0d", i), last_result, exp_valid);
            if (i % 5 != 4) begin
                a = 16'($urandom_range(0, 65535));
                b = 16'($urandom_range(0, 65535));
                in_valid = 1'b1;
                last_result = ref_add(a, b);
                exp_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
                exp_valid = 1'b0;
            end
            @(negedge clk);
        end
        check_result("rand_last", last_result, exp_valid);

        // Reset mid-operation: result already registered is cleared immediately
        a = 16'h00FF;
        b = 16'h0001;
        in_valid = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_result("reset_mid", 17'h0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_result("reset_after", 17'h0, 1'b0);

        // First operation after reset release
        a = 16'h8000;
        b = 16'h8000;
        in_valid = 1'b1;
        @(negedge clk);
        check_result("post_reset", ref_add(16'h8000, 16'h8000), 1'b1);
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
